// File: rtl/mesi_isc_coherence_monitor.sv
// Passive MESI coherence monitor: single-writer/multi-reader and encoding checks,
// per-CPU write-starvation watchdog, first-error capture. Optional coverage via MESI_ISC_MON_COVER_EN.
`ifndef MESI_ISC_TB_CPU_MESI_M
`define MESI_ISC_TB_CPU_MESI_M 4'b1001
`endif
`ifndef MESI_ISC_TB_CPU_MESI_E
`define MESI_ISC_TB_CPU_MESI_E 4'b0101
`endif
`ifndef MESI_ISC_TB_CPU_MESI_S
`define MESI_ISC_TB_CPU_MESI_S 4'b0011
`endif
`ifndef MESI_ISC_TB_CPU_MESI_I
`define MESI_ISC_TB_CPU_MESI_I 4'b0000
`endif
`ifndef MESI_ISC_TB_INS_NOP
`define MESI_ISC_TB_INS_NOP 4'd0
`endif
`ifndef MESI_ISC_TB_INS_WR
`define MESI_ISC_TB_INS_WR 4'd1
`endif
`ifndef MESI_ISC_TB_INS_RD
`define MESI_ISC_TB_INS_RD 4'd2
`endif

module mesi_isc_mon_wdog #(
    parameter int LINE_COUNT   = 10,
    parameter int STATE_WIDTH  = 4,
    parameter int ADDR_WIDTH   = 4,
    parameter int STARVE_LIMIT = 500
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    mon_en,
    input  logic [3:0]                              ins,
    input  logic [ADDR_WIDTH-1:0]                   ins_addr,
    input  logic                                    ins_ack,
    input  logic [LINE_COUNT-1:0][STATE_WIDTH-1:0]  line_state,
    output logic                                    starve_err
);
    localparam int CW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic {W_IDLE = 1'b0, W_PEND = 1'b1} wd_state_t;

    wd_state_t             state_q, state_nxt;
    logic [ADDR_WIDTH-1:0] addr_q, addr_nxt;
    logic [CW-1:0]         cnt_q, cnt_nxt;
    logic                  err_nxt;
    logic                  tgt_is_m;
    logic                  start;

    always_comb begin
        tgt_is_m = 1'b0;
        for (int l = 0; l < LINE_COUNT; l++)
            if (addr_q == ADDR_WIDTH'(l))
                tgt_is_m = (line_state[l] == STATE_WIDTH'(`MESI_ISC_TB_CPU_MESI_M));
    end

    // Out-of-range write addresses never arm the watchdog.
    assign start = mon_en && ins_ack && (ins == `MESI_ISC_TB_INS_WR) &&
                   ({1'b0, ins_addr} < (ADDR_WIDTH+1)'(LINE_COUNT));

    always_comb begin
        state_nxt = state_q;
        addr_nxt  = addr_q;
        cnt_nxt   = cnt_q;
        err_nxt   = starve_err;
        if (start) begin
            state_nxt = W_PEND;
            addr_nxt  = ins_addr;
            cnt_nxt   = '0;
        end else begin
            case (state_q)
                W_IDLE: cnt_nxt = '0;
                W_PEND: begin
                    if (tgt_is_m) begin
                        state_nxt = W_IDLE;
                        cnt_nxt   = '0;
                    end else if (cnt_q == CW'(STARVE_LIMIT - 1)) begin
                        state_nxt = W_IDLE;
                        cnt_nxt   = '0;
                        err_nxt   = 1'b1;
                    end else begin
                        cnt_nxt = cnt_q + 1'b1;
                    end
                end
                default: state_nxt = W_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= W_IDLE;
            addr_q     <= '0;
            cnt_q      <= '0;
            starve_err <= 1'b0;
        end else begin
            state_q    <= state_nxt;
            addr_q     <= addr_nxt;
            cnt_q      <= cnt_nxt;
            starve_err <= err_nxt;
        end
    end
endmodule

module mesi_isc_coherence_monitor #(
    parameter int CPU_COUNT    = 4,
    parameter int LINE_COUNT   = 10,
    parameter int STATE_WIDTH  = 4,
    parameter int ADDR_WIDTH   = 4,
    parameter int STARVE_LIMIT = 500,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      mon_en_i,
    input  logic [CPU_COUNT*LINE_COUNT*STATE_WIDTH-1:0] cache_state_i,
    input  logic [CPU_COUNT*4-1:0]                    tb_ins_i,
    input  logic [CPU_COUNT*ADDR_WIDTH-1:0]           tb_ins_addr_i,
    input  logic [CPU_COUNT-1:0]                      tb_ins_ack_i,
    output logic                                      viol_o,
    output logic [ADDR_WIDTH-1:0]                     viol_line_o,
    output logic                                      viol_sticky_o,
    output logic [CNT_WIDTH-1:0]                      viol_cnt_o,
    output logic [ADDR_WIDTH-1:0]                     first_line_o,
    output logic [CPU_COUNT-1:0]                      first_cpu_mask_o,
    output logic [CPU_COUNT-1:0]                      starve_err_o,
    output logic [CPU_COUNT*4-1:0]                    cov_seen_o
);
    localparam logic [STATE_WIDTH-1:0] ST_M = STATE_WIDTH'(`MESI_ISC_TB_CPU_MESI_M);
    localparam logic [STATE_WIDTH-1:0] ST_E = STATE_WIDTH'(`MESI_ISC_TB_CPU_MESI_E);
    localparam logic [STATE_WIDTH-1:0] ST_S = STATE_WIDTH'(`MESI_ISC_TB_CPU_MESI_S);
    localparam logic [STATE_WIDTH-1:0] ST_I = STATE_WIDTH'(`MESI_ISC_TB_CPU_MESI_I);

    logic [CPU_COUNT-1:0][LINE_COUNT-1:0][STATE_WIDTH-1:0] st;
    logic [LINE_COUNT-1:0][CPU_COUNT-1:0] noni_mask;
    logic [LINE_COUNT-1:0]                me_any, ill_any, line_viol;
    logic [ADDR_WIDTH-1:0]                low_line;
    logic [CPU_COUNT-1:0]                 low_mask;
    logic                                 viol_now;

    assign st = cache_state_i;

    always_comb begin
        noni_mask = '0;
        me_any    = '0;
        ill_any   = '0;
        line_viol = '0;
        for (int l = 0; l < LINE_COUNT; l++) begin
            for (int c = 0; c < CPU_COUNT; c++) begin
                noni_mask[l][c] = (st[c][l] != ST_I);
                if (st[c][l] == ST_M || st[c][l] == ST_E) me_any[l] = 1'b1;
                if (st[c][l] != ST_M && st[c][l] != ST_E &&
                    st[c][l] != ST_S && st[c][l] != ST_I) ill_any[l] = 1'b1;
            end
            // More than one holder: clearing the lowest set bit leaves something.
            line_viol[l] = ill_any[l] ||
                           (me_any[l] && ((noni_mask[l] & (noni_mask[l] - 1'b1)) != '0));
        end
    end

    always_comb begin
        low_line = '0;
        low_mask = '0;
        for (int l = LINE_COUNT - 1; l >= 0; l--) begin
            if (line_viol[l]) begin
                low_line = ADDR_WIDTH'(l);
                low_mask = noni_mask[l];
            end
        end
    end

    assign viol_now = mon_en_i && (|line_viol);

    always_ff @(posedge clk) begin
        if (rst) begin
            viol_o           <= 1'b0;
            viol_line_o      <= '0;
            viol_sticky_o    <= 1'b0;
            viol_cnt_o       <= '0;
            first_line_o     <= '0;
            first_cpu_mask_o <= '0;
        end else begin
            viol_o <= viol_now;
            if (viol_now) begin
                viol_line_o <= low_line;
                if (viol_cnt_o != '1) viol_cnt_o <= viol_cnt_o + 1'b1;
                if (!viol_sticky_o) begin
                    viol_sticky_o    <= 1'b1;
                    first_line_o     <= low_line;
                    first_cpu_mask_o <= low_mask;
                end
            end
        end
    end

    for (genvar c = 0; c < CPU_COUNT; c++) begin : g_wdog
        mesi_isc_mon_wdog #(
            .LINE_COUNT  (LINE_COUNT),
            .STATE_WIDTH (STATE_WIDTH),
            .ADDR_WIDTH  (ADDR_WIDTH),
            .STARVE_LIMIT(STARVE_LIMIT)
        ) u_wdog (
            .clk       (clk),
            .rst       (rst),
            .mon_en    (mon_en_i),
            .ins       (tb_ins_i[c*4 +: 4]),
            .ins_addr  (tb_ins_addr_i[c*ADDR_WIDTH +: ADDR_WIDTH]),
            .ins_ack   (tb_ins_ack_i[c]),
            .line_state(st[c]),
            .starve_err(starve_err_o[c])
        );
    end

`ifdef MESI_ISC_MON_COVER_EN
    logic [CPU_COUNT-1:0][3:0] cov_hit;

    always_comb begin
        cov_hit = '0;
        for (int c = 0; c < CPU_COUNT; c++)
            for (int l = 0; l < LINE_COUNT; l++) begin
                if (st[c][l] == ST_M) cov_hit[c][0] = 1'b1;
                if (st[c][l] == ST_E) cov_hit[c][1] = 1'b1;
                if (st[c][l] == ST_S) cov_hit[c][2] = 1'b1;
                if (st[c][l] == ST_I) cov_hit[c][3] = 1'b1;
            end
    end

    always_ff @(posedge clk) begin
        if (rst)           cov_seen_o <= '0;
        else if (mon_en_i) cov_seen_o <= cov_seen_o | cov_hit;
    end
`else
    assign cov_seen_o = '0;
`endif
endmodule

// File: doc/mesi_isc_coherence_monitor.md
Name: mesi_isc_coherence_monitor

Overview:
- Synthesizable, parametrised coherence monitor for the MESI ISC bench; passive, snoops every CPU's per-line cache_state array.
- Flags single-writer/multi-reader violations and illegal encodings, and runs a per-CPU write-starvation watchdog.
- Counts and captures the first error for post-mortem, so checking works without SVA support, including in FPGA/emulation builds.
- Instantiated in tb beside mesi_isc_tb_cpu0..N-1. State encodings are the `MESI_ISC_TB_CPU_MESI_{M,E,S,I}` macros; instruction encodings are `MESI_ISC_TB_INS_{NOP,WR,RD}`.

Parameters:
CPU_COUNT, 4, number of monitored CPUs (2..8)
LINE_COUNT, 10, cache lines per CPU
STATE_WIDTH, 4, width of one cache_state entry
ADDR_WIDTH, 4, width of instruction address; must satisfy 2**ADDR_WIDTH >= LINE_COUNT
STARVE_LIMIT, 500, cycles a write may stay pending before a starve error
CNT_WIDTH, 16, width of the violation counter

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
mon_en_i  in  1  enables checking; when low, no new errors or pendings are recorded
cache_state_i  in  CPU_COUNT*LINE_COUNT*STATE_WIDTH  flattened states; entry (c,l) at bits [(c*LINE_COUNT+l)*STATE_WIDTH +: STATE_WIDTH]
tb_ins_i  in  CPU_COUNT*4  per-CPU instruction
tb_ins_addr_i  in  CPU_COUNT*ADDR_WIDTH  per-CPU instruction address
tb_ins_ack_i  in  CPU_COUNT  per-CPU instruction accepted this cycle
viol_o  out  1  one-cycle pulse: a coherence violation was sampled in the previous cycle
viol_line_o  out  ADDR_WIDTH  lowest violating line for the current viol_o pulse
viol_sticky_o  out  1  set on the first violation; held until rst
viol_cnt_o  out  CNT_WIDTH  saturating count of violating cycles
first_line_o  out  ADDR_WIDTH  line of the first violation
first_cpu_mask_o  out  CPU_COUNT  CPUs holding a non-I state on first_line_o at the first violation
starve_err_o  out  CPU_COUNT  sticky per-CPU starvation error
cov_seen_o  out  CPU_COUNT*4  coverage bitmap, see Optional Feature

Behaviour:
- Reset: every output is 0, every pending write is cleared and every watchdog counter is 0. Reset asserted mid-operation clears all state on that edge.
- Per-line check is combinational on the sampled inputs. For each line l:
  - nonI = number of CPUs with state != I.
  - Line l is violating if either:
    - any CPU on l is M or E and nonI > 1; or
    - any entry on l is not one of M/E/S/I (illegal encoding).
  - All-S and all-I lines are legal.
- Reporting (registered, latency 1): if mon_en_i and at least one line violates in cycle N, then at N+1:
  - viol_o = 1;
  - viol_line_o = lowest violating index;
  - viol_cnt_o increments by 1 per violating cycle, regardless of how many lines violate, and saturates at all-ones.
  If no line violates, viol_o = 0 and viol_line_o holds its last value.
- First capture: on the first violating cycle after reset, latch first_line_o and first_cpu_mask_o and set viol_sticky_o. Later violations never overwrite them.
- Watchdog, per CPU c, two states:
  - IDLE -> PEND when mon_en_i && tb_ins_ack_i[c] && tb_ins_i[c]==WR. Latch the address and load the counter with 0.
  - In PEND, the counter increments each cycle.
  - PEND -> IDLE when cache_state(c, latched addr)==M, checked from the first cycle after acceptance.
  - If the counter reaches STARVE_LIMIT while still PEND, set starve_err_o[c] (sticky) and return to IDLE.
  - A new accepted WR while in PEND replaces the address and restarts the counter at 0. This takes priority over a same-cycle completion or timeout of the old write.
  - An accepted RD or NOP has no effect.
  - An address >= LINE_COUNT on an accepted WR is ignored (stays IDLE).
- mon_en_i deasserted: in-flight PEND counters keep running, but no new pendings, violations or counts are recorded.

Optional Feature:
- Macro MESI_ISC_MON_COVER_EN.
- Defined: cov_seen_o[c*4+k] is a sticky bit, set when any line of CPU c holds state k in a cycle with mon_en_i high. k: 0=M, 1=E, 2=S, 3=I. Cleared by rst.
- Undefined: cov_seen_o is tied to 0 and no coverage flops are synthesised.

Test Plan:
1. rst held 3 cycles with random inputs -> all outputs 0. Then all lines I for 10 cycles -> viol_o stays 0 and viol_cnt_o = 0.
2. CPU0 line 3 = M and CPU2 line 3 = S for 1 cycle -> one cycle later viol_o = 1, viol_line_o = 3, viol_cnt_o = 1, first_line_o = 3, first_cpu_mask_o = 4'b0101.
3. Violations on lines 7 and 2 in the same cycle, then line 5 three cycles later -> viol_line_o = 2, then 5. viol_cnt_o = 2. first_line_o stays 2.
4. CPU1 WR to addr 4 acked; CPU1 line 4 becomes M after 20 cycles -> starve_err_o[1] stays 0. Repeat with the state never reaching M -> starve_err_o[1] = 1 after STARVE_LIMIT cycles (500).
5. Force viol_cnt_o to saturate (CNT_WIDTH=4, 20 violating cycles) -> holds at 15. Assert rst mid-PEND -> counter, pending write and sticky bits all cleared.
6. With MESI_ISC_MON_COVER_EN: drive CPU3 through I -> E -> M -> S -> cov_seen_o[15:12] = 4'b1111. Without the macro -> cov_seen_o = 0.
